nonce_scheduler: RTL and testbench

- Sequences the SHA-256d miner datapath over a programmable nonce range.
- Latches a range from the processor, then repeatedly issues one nonce to the hash core and waits for its done pulse.
- Compares each returned hash against a 256-bit target and stops on the first hit, on range exhaustion, on abort, or on a core timeout.
- Sits between the processor's miner-control registers and the hash core; all signals run in the mining clock domain.

---
 rtl/miner_pkg.sv | 26 ++
 rtl/hash_target_compare.sv | 24 ++
 rtl/nonce_scheduler.sv | 179 +++++++++++++++++
 tb/tb_nonce_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// ============================================================================
//  Module   : miner_pkg
//  Purpose  : Shared types and defaults for the SHA-256d miner control path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package miner_pkg;

    localparam int NONCE_W_DEFAULT = 32;
    localparam int HASH_W_DEFAULT  = 256;
    localparam int TIMEOUT_DEFAULT = 4096;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT      = 3'd2,
        ST_CHECK     = 3'd3,
        ST_FOUND     = 3'd4,
        ST_EXHAUSTED = 3'd5,
        ST_ERROR     = 3'd6
    } nonce_sched_state_e;

endpackage

`default_nettype wire

// File: rtl/hash_target_compare.sv
// ============================================================================
//  Module   : hash_target_compare
//  Purpose  : Unsigned less-than between a returned hash and the target.
//             Purely combinational; the caller registers the result.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hash_target_compare
    import miner_pkg::*;
#(
    parameter int HASH_W = HASH_W_DEFAULT
) (
    input  logic [HASH_W-1:0] hash,
    input  logic [HASH_W-1:0] target,
    output logic              less
);

    // A hit is a hash strictly below the threshold; equality is a miss.
    assign less = (hash < target);

endmodule

`default_nettype wire

// File: rtl/nonce_scheduler.sv
// ============================================================================
//  Module   : nonce_scheduler
//  Purpose  : Walks a nonce range through the hash core one nonce at a time,
//             stopping on a hit, range exhaustion, abort or core timeout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nonce_scheduler
    import miner_pkg::*;
#(
    parameter int NONCE_W        = NONCE_W_DEFAULT,
    parameter int HASH_W         = HASH_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_first,
    input  logic [NONCE_W-1:0] nonce_last,
    input  logic [HASH_W-1:0]  target,
    output logic               core_start,
    output logic [NONCE_W-1:0] core_nonce,
    input  logic               core_done,
    input  logic [HASH_W-1:0]  core_hash,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic               error,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [CNT_W-1:0]   hash_count
);

    // The counter only has to reach TIMEOUT_CYCLES-2: the ISSUE cycle plus
    // TIMEOUT_CYCLES-1 WAIT cycles put ERROR exactly TIMEOUT_CYCLES after core_start.
    localparam int                 c_TMO_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LIMIT = c_TMO_W'(TIMEOUT_CYCLES - 2);

    nonce_sched_state_e r_state;
    nonce_sched_state_e w_stateNext;

    logic [NONCE_W-1:0] r_cur;
    logic [NONCE_W-1:0] r_last;
    logic [NONCE_W-1:0] r_foundNonce;
    logic [HASH_W-1:0]  r_target;
    logic               r_hit;
    logic [c_TMO_W-1:0] r_tmo;
    logic [CNT_W-1:0]   r_hashCount;

    logic               w_less;
    logic               w_canStart;
    logic               w_startOk;

    hash_target_compare #(
        .HASH_W (HASH_W)
    ) u_compare (
        .hash   (core_hash),
        .target (r_target),
        .less   (w_less)
    );

    assign w_canStart = (r_state == ST_IDLE)  || (r_state == ST_FOUND) ||
                        (r_state == ST_EXHAUSTED) || (r_state == ST_ERROR);
    assign w_startOk  = start && !abort && w_canStart;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        w_stateNext = r_state;
        if (abort) begin
            w_stateNext = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_ERROR: begin
                    if (start) begin
                        w_stateNext = (nonce_first > nonce_last) ? ST_EXHAUSTED : ST_ISSUE;
                    end
                end
                ST_ISSUE: w_stateNext = ST_WAIT;
                ST_WAIT: begin
                    if (core_done) begin
                        w_stateNext = ST_CHECK;
                    end else if (r_tmo == c_TMO_LIMIT) begin
                        w_stateNext = ST_ERROR;
                    end
                end
                ST_CHECK: begin
                    if (r_hit) begin
                        w_stateNext = ST_FOUND;
                    end else if (r_cur == r_last) begin
                        w_stateNext = ST_EXHAUSTED;
                    end else begin
                        w_stateNext = ST_ISSUE;
                    end
                end
                default: w_stateNext = ST_IDLE;
            endcase
        end
    end

    // Status and core handshake outputs decoded from the state.
    always_comb begin
        core_start = 1'b0;
        busy       = 1'b0;
        found      = 1'b0;
        exhausted  = 1'b0;
        error      = 1'b0;
        case (r_state)
            ST_ISSUE:     begin core_start = 1'b1; busy = 1'b1; end
            ST_WAIT:      busy      = 1'b1;
            ST_CHECK:     busy      = 1'b1;
            ST_FOUND:     found     = 1'b1;
            ST_EXHAUSTED: exhausted = 1'b1;
            ST_ERROR:     error     = 1'b1;
            default:      ;
        endcase
    end

    // Range/target latch, nonce walk, timeout, hit capture and statistics.
    // Abort leaves this state untouched so hash_count and found_nonce survive.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cur        <= '0;
            r_last       <= '0;
            r_target     <= '0;
            r_foundNonce <= '0;
            r_hit        <= 1'b0;
            r_tmo        <= '0;
            r_hashCount  <= '0;
        end else if (w_startOk) begin
            r_cur       <= nonce_first;
            r_last      <= nonce_last;
            r_target    <= target;
            r_hit       <= 1'b0;
            r_hashCount <= '0;
        end else if (!abort) begin
            case (r_state)
                ST_ISSUE: r_tmo <= '0;
                ST_WAIT: begin
                    if (core_done) begin
                        r_hit <= w_less;
                        if (r_hashCount != {CNT_W{1'b1}}) begin
                            r_hashCount <= r_hashCount + 1'b1;
                        end
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_CHECK: begin
                    // Equality is tested before incrementing so the top of
                    // the nonce space never wraps back to zero.
                    if (r_hit) begin
                        r_foundNonce <= r_cur;
                    end else if (r_cur != r_last) begin
                        r_cur <= r_cur + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_nonce  = r_cur;
    assign found_nonce = r_foundNonce;
    assign hash_count  = r_hashCount;

endmodule

`default_nettype wire

// File: tb/tb_nonce_scheduler.sv
// ============================================================================
//  Module   : tb_nonce_scheduler
//  Purpose  : Directed, table-driven bench for nonce_scheduler with a
//             behavioural hash core of programmable latency.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nonce_scheduler;

    localparam int NW = 32;
    localparam int HW = 256;
    localparam int CW = 3;
    localparam logic [HW-1:0] T = {64'h0000_0000_FFFF_0000, 64'h1234_5678_9ABC_DEF0,
                                   64'h0F0F_0F0F_F0F0_F0F0, 64'h8000_0000_0000_0001};

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NW-1:0] nonce_first = '0;
    logic [NW-1:0] nonce_last  = '0;
    logic [HW-1:0] target      = '0;
    logic          core_start;
    logic [NW-1:0] core_nonce;
    logic          core_done = 1'b0;
    logic [HW-1:0] core_hash = '0;
    logic          busy, found, exhausted, error;
    logic [NW-1:0] found_nonce;
    logic [CW-1:0] hash_count;

    nonce_scheduler #(
        .NONCE_W(NW), .HASH_W(HW), .TIMEOUT_CYCLES(8), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .nonce_first(nonce_first), .nonce_last(nonce_last), .target(target),
        .core_start(core_start), .core_nonce(core_nonce),
        .core_done(core_done), .core_hash(core_hash),
        .busy(busy), .found(found), .exhausted(exhausted), .error(error),
        .found_nonce(found_nonce), .hash_count(hash_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural hash core ----------------
    int            lat     = 5;
    bit            silent  = 1'b0;
    bit            hitEn   = 1'b0;
    bit            missEq  = 1'b0;
    bit            inject  = 1'b0;
    logic [NW-1:0] hitNonce = '0;
    logic [NW-1:0] issued[$];

    initial begin : core_model
        bit            pend = 1'b0;
        int            cnt  = 0;
        logic [NW-1:0] cap  = '0;
        forever begin
            @(negedge clock);
            core_done = 1'b0;
            if (inject) begin
                inject    = 1'b0;
                core_done = 1'b1;
                core_hash = T - 1;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend      = 1'b0;
                    core_done = 1'b1;
                    if (hitEn && cap == hitNonce) core_hash = T - 1;
                    else if (missEq)              core_hash = T;
                    else                          core_hash = T + 1;
                end
            end
            if (core_start) begin
                issued.push_back(core_nonce);
                if (!silent) begin
                    pend = 1'b1;
                    cnt  = lat;
                    cap  = core_nonce;
                end
            end
        end
    end

    // Launch a range, then scramble the live inputs so only latched copies matter.
    task automatic startRange(input logic [NW-1:0] f, input logic [NW-1:0] l);
        @(negedge clock);
        nonce_first = f;
        nonce_last  = l;
        target      = T;
        start       = 1'b1;
        @(posedge clock);
        #1;
        start       = 1'b0;
        nonce_first = '1;
        nonce_last  = '0;
        target      = '0;
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_core_start"},  64'(core_start),  64'd0);
        chk({tag, "_core_nonce"},  64'(core_nonce),  64'd0);
        chk({tag, "_busy"},        64'(busy),        64'd0);
        chk({tag, "_found"},       64'(found),       64'd0);
        chk({tag, "_exhausted"},   64'(exhausted),   64'd0);
        chk({tag, "_error"},       64'(error),       64'd0);
        chk({tag, "_found_nonce"}, 64'(found_nonce), 64'd0);
        chk({tag, "_hash_count"},  64'(hash_count),  64'd0);
    endtask

    // Edges after the accepting edge until a terminal flag shows (bounded).
    task automatic waitTerminal(output int cycles);
        cycles = 0;
        while (!(found || exhausted || error) && cycles < 300) begin
            @(posedge clock);
            #1;
            cycles++;
        end
    endtask

    typedef struct {
        logic [NW-1:0] first;
        logic [NW-1:0] last;
        bit            hitEn;
        logic [NW-1:0] hitNonce;
        bit            missEq;
        int            lat;
        bit            expFound;
        bit            expExh;
        logic [NW-1:0] expFoundNonce;
        int            expCount;
        int            expIssues;
        int            expCycles;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    initial begin
        int cyc;

        vecs[0] = '{32'h10, 32'h13, 1'b0, 32'h0, 1'b0, 5, 1'b0, 1'b1, 32'h0, 4, 4, 28};
        vecs[1] = '{32'h42A14690, 32'h42A146A0, 1'b1, 32'h42A14695, 1'b0, 5, 1'b1, 1'b0, 32'h42A14695, 6, 6, 42};
        vecs[2] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 3, 1'b0, 1'b1, 32'h0, 2, 2, 10};
        vecs[3] = '{32'h5, 32'h4, 1'b0, 32'h0, 1'b0, 5, 1'b0, 1'b1, 32'h0, 0, 0, 0};
        vecs[4] = '{32'h7, 32'h8, 1'b0, 32'h0, 1'b1, 1, 1'b0, 1'b1, 32'h0, 2, 2, 6};
        vecs[5] = '{32'd100, 32'd200, 1'b1, 32'd100, 1'b0, 1, 1'b1, 1'b0, 32'd100, 1, 1, 3};
        vecs[6] = '{32'd0, 32'd9, 1'b0, 32'h0, 1'b0, 1, 1'b0, 1'b1, 32'h0, 7, 10, 30};
        vecs[7] = '{32'h55, 32'h55, 1'b1, 32'h55, 1'b0, 2, 1'b1, 1'b0, 32'h55, 1, 1, 4};
        vecs[8] = '{32'd1, 32'd3, 1'b1, 32'd3, 1'b0, 7, 1'b1, 1'b0, 32'd3, 3, 3, 27};

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        checkAllZero("reset");
        @(negedge clock);
        reset = 1'b0;

        // Table-driven ranges.
        for (int v = 0; v < NV; v++) begin
            lat      = vecs[v].lat;
            hitEn    = vecs[v].hitEn;
            hitNonce = vecs[v].hitNonce;
            missEq   = vecs[v].missEq;
            silent   = 1'b0;
            issued.delete();
            startRange(vecs[v].first, vecs[v].last);
            waitTerminal(cyc);
            chk($sformatf("v%0d_cycles", v), 64'(cyc), 64'(vecs[v].expCycles));
            repeat (3) @(posedge clock);
            #1;
            chk($sformatf("v%0d_found", v),     64'(found),       64'(vecs[v].expFound));
            chk($sformatf("v%0d_exhausted", v), 64'(exhausted),  64'(vecs[v].expExh));
            chk($sformatf("v%0d_error", v),     64'(error),       64'd0);
            chk($sformatf("v%0d_busy", v),      64'(busy),        64'd0);
            chk($sformatf("v%0d_count", v),     64'(hash_count),  64'(vecs[v].expCount));
            chk($sformatf("v%0d_issues", v),    64'(issued.size()), 64'(vecs[v].expIssues));
            if (vecs[v].expFound)
                chk($sformatf("v%0d_found_nonce", v), 64'(found_nonce), 64'(vecs[v].expFoundNonce));
            for (int i = 0; i < issued.size() && i < vecs[v].expIssues; i++)
                chk($sformatf("v%0d_nonce%0d", v, i), 64'(issued[i]), 64'(vecs[v].first + NW'(i)));
        end

        // Core timeout: silent core, ERROR exactly 8 cycles after core_start.
        silent = 1'b1;
        hitEn  = 1'b0;
        missEq = 1'b0;
        issued.delete();
        startRange(32'h20, 32'h30);
        waitTerminal(cyc);
        chk("tmo_cycles", 64'(cyc), 64'd8);
        chk("tmo_error",  64'(error), 64'd1);
        chk("tmo_busy",   64'(busy),  64'd0);
        chk("tmo_count",  64'(hash_count), 64'd0);
        chk("tmo_issues", 64'(issued.size()), 64'd1);
        silent = 1'b0;
        lat    = 2;
        issued.delete();
        startRange(32'h20, 32'h20);
        chk("tmo_restart_error", 64'(error), 64'd0);
        chk("tmo_restart_busy",  64'(busy),  64'd1);
        waitTerminal(cyc);
        chk("tmo_restart_exh",    64'(exhausted), 64'd1);
        chk("tmo_restart_issues", 64'(issued.size()), 64'd1);
        if (issued.size() > 0) chk("tmo_restart_nonce", 64'(issued[0]), 64'h20);

        // Abort in WAIT with a result in flight, start-while-busy ignored,
        // then a stray done that would otherwise be a hit.
        lat = 6;
        issued.delete();
        startRange(32'h100, 32'h1FF);
        begin
            int guard = 0;
            while (issued.size() < 1 && guard < 100) begin @(negedge clock); #1; guard++; end
            nonce_first = 32'h900; nonce_last = 32'h900; target = T; start = 1'b1;
            @(negedge clock); #1;
            start = 1'b0; nonce_first = '1; nonce_last = '0; target = '0;
            guard = 0;
            while (issued.size() < 3 && guard < 100) begin @(negedge clock); #1; guard++; end
        end
        chk("abort_pre_count", 64'(hash_count), 64'd2);
        @(negedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        chk("abort_busy",      64'(busy),       64'd0);
        chk("abort_found",     64'(found),      64'd0);
        chk("abort_exhausted", 64'(exhausted),  64'd0);
        chk("abort_error",     64'(error),      64'd0);
        chk("abort_count",     64'(hash_count), 64'd2);
        @(negedge clock); @(negedge clock); #1;
        inject = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("stray_busy",   64'(busy),  64'd0);
        chk("stray_found",  64'(found), 64'd0);
        chk("stray_count",  64'(hash_count), 64'd2);
        chk("stray_issues", 64'(issued.size()), 64'd3);
        if (issued.size() >= 3) begin
            chk("busy_start_nonce1", 64'(issued[1]), 64'h101);
            chk("busy_start_nonce2", 64'(issued[2]), 64'h102);
        end

        // Abort beats a simultaneous start.
        @(negedge clock);
        nonce_first = 32'h700; nonce_last = 32'h700; target = T;
        start = 1'b1; abort = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_vs_start_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clock);
        #1;
        chk("abort_vs_start_issues", 64'(issued.size()), 64'd3);

        // Reset while in ISSUE: everything clears and nothing more is issued.
        issued.delete();
        startRange(32'h300, 32'h3FF);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checkAllZero("rst_issue");
        repeat (10) @(posedge clock);
        #1;
        chk("rst_issue_issues", 64'(issued.size()), 64'd1);
        checkAllZero("rst_issue_later");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
